// File: rtl/ysyx_22041211_lsu.sv
// Load/store unit: single-beat data-memory access with lane alignment,
// sign/zero extension, misalignment and timeout error reporting.
module ysyx_22041211_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [1:0]  in_store_type,
  input  logic [2:0]  in_load_type,
  input  logic        in_wd,
  input  logic [4:0]  in_wreg,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_wd,
  output logic [4:0]  out_wreg,
  output logic        err_o
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ      = 2'd1,
    S_WAIT_RSP = 2'd2,
    S_DONE     = 2'd3
  } state_e;

  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LH  = 3'b010;
  localparam logic [2:0] LD_LW  = 3'b011;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       ld_type, ld_type_n;
  logic [1:0]       ofs, ofs_n;
  logic             wd_q, wd_n;

  logic [31:0] mem_addr_n, mem_wdata_n, out_data_n;
  logic [3:0]  mem_wmask_n;
  logic        mem_wen_n, out_wd_n, err_n;
  logic [4:0]  out_wreg_n;

  logic        is_store, is_load, misaligned;
  logic [31:0] st_data;
  logic [3:0]  st_mask;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Request classification and alignment check on the incoming bundle
  always_comb begin
    is_store   = (in_store_type != 2'b00);
    is_load    = (in_load_type != 3'b000);
    misaligned = 1'b0;
    if (is_store) begin
      case (in_store_type)
        2'b10:   misaligned = in_addr[0];
        2'b11:   misaligned = |in_addr[1:0];
        default: misaligned = 1'b0;
      endcase
    end else if (is_load) begin
      case (in_load_type)
        LD_LB, LD_LBU: misaligned = 1'b0;
        LD_LH, LD_LHU: misaligned = in_addr[0];
        default:       misaligned = |in_addr[1:0];
      endcase
    end
  end

  // Store data replicated across lanes; mask selects the live bytes
  always_comb begin
    st_data = 32'h0;
    st_mask = 4'h0;
    case (in_store_type)
      2'b01: begin
        st_data = {4{in_wdata[7:0]}};
        st_mask = 4'b0001 << in_addr[1:0];
      end
      2'b10: begin
        st_data = {2{in_wdata[15:0]}};
        st_mask = 4'b0011 << in_addr[1:0];
      end
      2'b11: begin
        st_data = in_wdata;
        st_mask = 4'b1111;
      end
      default: ;
    endcase
  end

  // Load response lane selection and extension
  always_comb begin
    case (ofs)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = ofs[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (ld_type)
      LD_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      LD_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      LD_LBU:  ld_data = {24'h0, ld_byte};
      LD_LHU:  ld_data = {16'h0, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    ld_type_n   = ld_type;
    ofs_n       = ofs;
    wd_n        = wd_q;
    mem_addr_n  = mem_addr;
    mem_wen_n   = mem_wen;
    mem_wdata_n = mem_wdata;
    mem_wmask_n = mem_wmask;
    out_data_n  = out_data;
    out_wd_n    = out_wd;
    out_wreg_n  = out_wreg;
    err_n       = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          out_wreg_n = in_wreg;
          ofs_n      = in_addr[1:0];
          ld_type_n  = in_load_type;
          wd_n       = in_wd;
          if (!is_store && !is_load) begin
            state_n    = S_DONE;
            out_data_n = in_addr;
            out_wd_n   = in_wd;
          end else if (misaligned) begin
            state_n    = S_DONE;
            out_data_n = 32'h0;
            out_wd_n   = 1'b0;
            err_n      = 1'b1;
          end else begin
            state_n     = S_REQ;
            mem_addr_n  = {in_addr[31:2], 2'b00};
            mem_wen_n   = is_store;
            mem_wdata_n = st_data;
            mem_wmask_n = st_mask;
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          state_n = S_WAIT_RSP;
          cnt_n   = '0;
        end
      end
      S_WAIT_RSP: begin
        if (mem_rsp_valid) begin
          state_n    = S_DONE;
          out_data_n = mem_wen ? 32'h0 : ld_data;
          out_wd_n   = mem_wen ? 1'b0 : wd_q;
        end else if (cnt == CNT_LAST) begin
          state_n    = S_DONE;
          out_data_n = 32'h0;
          out_wd_n   = 1'b0;
          err_n      = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      ld_type       <= 3'b000;
      ofs           <= 2'b00;
      wd_q          <= 1'b0;
      in_ready      <= 1'b1;
      mem_req_valid <= 1'b0;
      mem_addr      <= 32'h0;
      mem_wen       <= 1'b0;
      mem_wdata     <= 32'h0;
      mem_wmask     <= 4'h0;
      out_valid     <= 1'b0;
      out_data      <= 32'h0;
      out_wd        <= 1'b0;
      out_wreg      <= 5'h0;
      err_o         <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      ld_type       <= ld_type_n;
      ofs           <= ofs_n;
      wd_q          <= wd_n;
      in_ready      <= (state_n == S_IDLE);
      mem_req_valid <= (state_n == S_REQ);
      mem_addr      <= mem_addr_n;
      mem_wen       <= mem_wen_n;
      mem_wdata     <= mem_wdata_n;
      mem_wmask     <= mem_wmask_n;
      out_valid     <= (state_n == S_DONE);
      out_data      <= out_data_n;
      out_wd        <= out_wd_n;
      out_wreg      <= out_wreg_n;
      err_o         <= err_n;
    end
  end

endmodule

// File: tb/tb_ysyx_22041211_lsu.sv
// Directed bench for the load/store unit: pass-through, lanes, extension,
// backpressure, misalignment, timeout and mid-request reset.
module tb_ysyx_22041211_lsu;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [1:0]  in_store_type;
  logic [2:0]  in_load_type;
  logic        in_wd;
  logic [4:0]  in_wreg;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_wd;
  logic [4:0]  out_wreg;
  logic        err_o;

  int total = 0;
  int bad   = 0;

  ysyx_22041211_lsu dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_store_type(in_store_type),
    .in_load_type(in_load_type), .in_wd(in_wd), .in_wreg(in_wreg),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rsp_valid(mem_rsp_valid),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_wd(out_wd), .out_wreg(out_wreg),
    .err_o(err_o)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] st,
                       input logic [2:0] ld, input logic wd, input logic [4:0] wreg);
    in_addr       = a;
    in_wdata      = d;
    in_store_type = st;
    in_load_type  = ld;
    in_wd         = wd;
    in_wreg       = wreg;
    in_valid      = 1'b1;
    step();
    in_valid      = 1'b0;
  endtask

  // Memory op with immediate ready and response; returns in the first DONE cycle
  task automatic do_mem(input string tag, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] st, input logic [2:0] ld, input logic [31:0] rdata);
    mem_req_ready = 1'b1;
    mem_rdata     = rdata;
    issue(a, d, st, ld, 1'b1, 5'd7);
    chk({tag, "_req"}, 32'(mem_req_valid), 32'd1);
    step();
    chk({tag, "_wait"}, 32'(out_valid), 32'd0);
    mem_rsp_valid = 1'b1;
    step();
    mem_rsp_valid = 1'b0;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  initial begin
    int n;
    reset = 1'b1; in_valid = 1'b0; in_addr = 32'h0; in_wdata = 32'h0;
    in_store_type = 2'b00; in_load_type = 3'b000; in_wd = 1'b0; in_wreg = 5'd0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = 32'h0; out_ready = 1'b1;
    step(); step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    reset = 1'b0;
    step();

    // ALU pass-through
    issue(32'h0000_1234, 32'h0, 2'b00, 3'b000, 1'b1, 5'd5);
    chk("alu_valid", 32'(out_valid), 32'd1);
    chk("alu_data", out_data, 32'h0000_1234);
    chk("alu_wreg", 32'(out_wreg), 32'd5);
    chk("alu_wd", 32'(out_wd), 32'd1);
    chk("alu_noreq", 32'(mem_req_valid), 32'd0);
    step();
    chk("alu_back_idle", 32'(in_ready), 32'd1);
    chk("alu_drop", 32'(out_valid), 32'd0);

    // SB store at offset 3
    mem_req_ready = 1'b1;
    issue(32'h8000_0003, 32'hAABB_CCDD, 2'b01, 3'b000, 1'b1, 5'd3);
    chk("sb_req", 32'(mem_req_valid), 32'd1);
    chk("sb_addr", mem_addr, 32'h8000_0000);
    chk("sb_mask", 32'(mem_wmask), 32'h8);
    chk("sb_wdata", mem_wdata, 32'hDDDD_DDDD);
    chk("sb_wen", 32'(mem_wen), 32'd1);
    step();
    mem_rsp_valid = 1'b1;
    step();
    mem_rsp_valid = 1'b0;
    chk("sb_done", 32'(out_valid), 32'd1);
    chk("sb_wd", 32'(out_wd), 32'd0);
    chk("sb_err", 32'(err_o), 32'd0);
    step();

    // Loads on 0x80FF7F01
    do_mem("lb2", 32'h0000_0102, 32'h0, 2'b00, 3'b001, 32'h80FF_7F01);
    chk("lb2_data", out_data, 32'hFFFF_FFFF);
    chk("lb2_wd", 32'(out_wd), 32'd1);
    chk("lb2_wen", 32'(mem_wen), 32'd0);
    chk("lb2_mask", 32'(mem_wmask), 32'h0);
    step();
    do_mem("lhu2", 32'h0000_0002, 32'h0, 2'b00, 3'b101, 32'h80FF_7F01);
    chk("lhu2_data", out_data, 32'h0000_80FF);
    step();
    do_mem("lb1", 32'h0000_0001, 32'h0, 2'b00, 3'b001, 32'h80FF_7F01);
    chk("lb1_data", out_data, 32'h0000_007F);
    step();
    do_mem("lh2", 32'h0000_0042, 32'h0, 2'b00, 3'b010, 32'h80FF_7F01);
    chk("lh2_data", out_data, 32'hFFFF_80FF);
    step();
    do_mem("lw0", 32'h0000_0040, 32'h0, 2'b00, 3'b011, 32'h80FF_7F01);
    chk("lw0_data", out_data, 32'h80FF_7F01);
    step();

    // Store wins over load when both types are set
    do_mem("both", 32'h0000_0008, 32'hCAFE_BABE, 2'b11, 3'b001, 32'h1111_1111);
    chk("both_wen", 32'(mem_wen), 32'd1);
    chk("both_mask", 32'(mem_wmask), 32'hF);
    chk("both_wdata", mem_wdata, 32'hCAFE_BABE);
    chk("both_wd", 32'(out_wd), 32'd0);
    step();

    // Request backpressure: SH at 0x6
    mem_req_ready = 1'b0;
    issue(32'h0000_0006, 32'h1234_ABCD, 2'b10, 3'b000, 1'b0, 5'd1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_req", 32'(mem_req_valid), 32'd1);
      chk("bp_addr", mem_addr, 32'h0000_0004);
      chk("bp_mask", 32'(mem_wmask), 32'hC);
      chk("bp_wdata", mem_wdata, 32'hABCD_ABCD);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    mem_req_ready = 1'b1;
    step();
    chk("bp_req_drop", 32'(mem_req_valid), 32'd0);
    mem_rsp_valid = 1'b1;
    step();
    mem_rsp_valid = 1'b0;
    chk("bp_done", 32'(out_valid), 32'd1);
    step();

    // Output backpressure: LBU at offset 3 held while out_ready low
    out_ready = 1'b0;
    do_mem("obp", 32'h0000_0003, 32'h0, 2'b00, 3'b100, 32'h80FF_7F01);
    mem_rdata = 32'h0000_0000;
    for (int i = 0; i < 2; i++) begin
      chk("obp_data", out_data, 32'h0000_0080);
      chk("obp_valid", 32'(out_valid), 32'd1);
      chk("obp_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("obp_release", 32'(out_valid), 32'd0);

    // Misaligned LW
    issue(32'h0000_0002, 32'h0, 2'b00, 3'b011, 1'b1, 5'd9);
    chk("mis_valid", 32'(out_valid), 32'd1);
    chk("mis_err", 32'(err_o), 32'd1);
    chk("mis_wd", 32'(out_wd), 32'd0);
    chk("mis_noreq", 32'(mem_req_valid), 32'd0);
    step();
    chk("mis_err_pulse", 32'(err_o), 32'd0);
    chk("mis_idle", 32'(in_ready), 32'd1);

    // Timeout: no response
    out_ready = 1'b0;
    mem_req_ready = 1'b1;
    issue(32'h0000_0010, 32'h0, 2'b00, 3'b011, 1'b1, 5'd4);
    step();
    mem_req_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 400) begin
      step();
      n++;
    end
    chk("to_reached", 32'(out_valid), 32'd1);
    chk("to_cycles", 32'(n >= 255 && n <= 256), 32'd1);
    chk("to_err", 32'(err_o), 32'd1);
    chk("to_wd", 32'(out_wd), 32'd0);
    mem_rsp_valid = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_rsp_valid = 1'b0;
    chk("to_err_pulse", 32'(err_o), 32'd0);
    chk("to_late_data", out_data, 32'h0);
    chk("to_late_wd", 32'(out_wd), 32'd0);
    out_ready = 1'b1;
    step();
    chk("to_idle", 32'(in_ready), 32'd1);
    mem_rsp_valid = 1'b1;
    step();
    mem_rsp_valid = 1'b0;
    chk("idle_rsp_ignored", 32'(out_valid), 32'd0);

    // Reset during REQ
    issue(32'h0000_0020, 32'h5555_5555, 2'b11, 3'b000, 1'b0, 5'd2);
    chk("rr_req", 32'(mem_req_valid), 32'd1);
    reset = 1'b1;
    step();
    chk("rr_req_drop", 32'(mem_req_valid), 32'd0);
    chk("rr_in_ready", 32'(in_ready), 32'd1);
    chk("rr_out_valid", 32'(out_valid), 32'd0);
    reset = 1'b0;
    mem_rsp_valid = 1'b1;
    step();
    mem_rsp_valid = 1'b0;
    chk("rr_rsp_ignored", 32'(out_valid), 32'd0);
    chk("rr_still_idle", 32'(in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
